// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selectors and the occupancy-counter width helper.
// No logic, no latency, no flow control.
// Common to the single-clock FIFO and the dual-clock FIFO family.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Counter must hold 0..DEPTH inclusive, hence DEPTH+1 states.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Write/read handshake and status bundle for fifo_sync_flags.
// Pure wiring, zero latency.
// Producer holds wr_en/rd_en; the FIFO rejects writes while full and reads while empty.
interface fifo_sync_flags_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = count_width(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, din, rd_en, clr_err,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, clr_err,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage array with synchronous write and asynchronous read.
// Write lands at the clock edge; read data follows raddr combinationally.
// No flow control; the owner guarantees addresses stay below DEPTH.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky error flags.
// Latency: STD mode dout one cycle after rd_en; FWFT mode head word visible the cycle after its write.
// Backpressure: writes dropped while full, reads dropped while empty; both raise sticky errors.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = FIFO_MODE_STD
) (
    input  logic              clk,
    input  logic              reset_n,
    fifo_sync_flags_if.slave  bus
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW   = count_width(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_flags: DEPTH must be at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_sync_flags: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync_flags: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    logic             full_q;
    logic             empty_q;
    logic             af_q;
    logic             ae_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] rdata;

    // Acceptance looks only at registered flags, so a pop cannot make room for a same-cycle push.
    assign wr_acc = bus.wr_en & ~full_q;
    assign rd_acc = bus.rd_en & ~empty_q;

    always_comb begin
        count_nxt = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            count_q     <= count_nxt;
            full_q      <= (count_nxt == CW'(DEPTH));
            empty_q     <= (count_nxt == '0);
            af_q        <= (count_nxt >= CW'(AF_THRESH));
            ae_q        <= (count_nxt <= CW'(AE_THRESH));
            overflow_q  <= (bus.wr_en & full_q)  | (overflow_q  & ~bus.clr_err);
            underflow_q <= (bus.rd_en & empty_q) | (underflow_q & ~bus.clr_err);
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.din),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign bus.dout       = empty_q ? '0 : rdata;
        assign bus.dout_valid = ~empty_q;
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;
        logic             dv_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dout_q <= '0;
                dv_q   <= 1'b0;
            end else begin
                dv_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= rdata;
                end
            end
        end

        assign bus.dout       = dout_q;
        assign bus.dout_valid = dv_q;
    end

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags: 16-deep standard, 5-deep wrap, 4-deep FWFT instances.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fifo_sync_flags;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fifo_sync_flags_if #(.WIDTH(8), .DEPTH(16)) b16 ();
    fifo_sync_flags_if #(.WIDTH(8), .DEPTH(5))  b5  ();
    fifo_sync_flags_if #(.WIDTH(8), .DEPTH(4))  bfw ();

    fifo_sync_flags #(.WIDTH(8), .DEPTH(16), .FWFT(FIFO_MODE_STD))
        u_std16 (.clk(clk), .reset_n(reset_n), .bus(b16));
    fifo_sync_flags #(.WIDTH(8), .DEPTH(5), .FWFT(FIFO_MODE_STD))
        u_std5  (.clk(clk), .reset_n(reset_n), .bus(b5));
    fifo_sync_flags #(.WIDTH(8), .DEPTH(4), .FWFT(FIFO_MODE_FWFT))
        u_fwft4 (.clk(clk), .reset_n(reset_n), .bus(bfw));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {b16.wr_en, b16.rd_en, b16.clr_err, b16.din} = '0;
        {b5.wr_en,  b5.rd_en,  b5.clr_err,  b5.din}  = '0;
        {bfw.wr_en, bfw.rd_en, bfw.clr_err, bfw.din} = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("rst_count",  32'(b16.count), 0);
        check("rst_empty",  32'(b16.empty), 1);
        check("rst_ae",     32'(b16.almost_empty), 1);
        check("rst_full",   32'(b16.full), 0);
        check("rst_af",     32'(b16.almost_full), 0);
        check("rst_dout",   32'(b16.dout), 0);
        check("rst_dv",     32'(b16.dout_valid), 0);
        check("rst_ovf",    32'(b16.overflow), 0);
        check("rst_unf",    32'(b16.underflow), 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // fill 0x01..0x10, then one write too many
        for (int i = 1; i <= 16; i++) begin
            b16.wr_en = 1'b1;
            b16.din   = 8'(i);
            tick();
            check("fill_count", 32'(b16.count), i);
            check("fill_full",  32'(b16.full), 32'(i == 16));
            check("fill_af",    32'(b16.almost_full), 32'(i >= 14));
            check("fill_ae",    32'(b16.almost_empty), 32'(i <= 2));
            check("fill_empty", 32'(b16.empty), 0);
        end
        b16.din = 8'h11;
        tick();
        b16.wr_en = 1'b0;
        check("ovf_set",   32'(b16.overflow), 1);
        check("ovf_count", 32'(b16.count), 16);
        check("ovf_full",  32'(b16.full), 1);

        for (int i = 1; i <= 16; i++) begin
            b16.rd_en = 1'b1;
            tick();
            check("drain_dout",  32'(b16.dout), i);
            check("drain_dv",    32'(b16.dout_valid), 1);
            check("drain_count", 32'(b16.count), 16 - i);
        end
        b16.rd_en = 1'b0;
        tick();
        check("drain_dv_low", 32'(b16.dout_valid), 0);
        check("drain_hold",   32'(b16.dout), 32'h10);
        check("drain_empty",  32'(b16.empty), 1);

        // underflow and clear
        b16.rd_en = 1'b1;
        tick();
        b16.rd_en = 1'b0;
        check("unf_set",   32'(b16.underflow), 1);
        check("unf_dout",  32'(b16.dout), 32'h10);
        check("unf_count", 32'(b16.count), 0);
        check("unf_dv",    32'(b16.dout_valid), 0);
        check("unf_ovf",   32'(b16.overflow), 1);
        b16.clr_err = 1'b1;
        tick();
        b16.clr_err = 1'b0;
        check("clr_unf", 32'(b16.underflow), 0);
        check("clr_ovf", 32'(b16.overflow), 0);
        b16.clr_err = 1'b1;
        b16.rd_en   = 1'b1;
        tick();
        b16.clr_err = 1'b0;
        b16.rd_en   = 1'b0;
        check("set_wins_unf", 32'(b16.underflow), 1);
        b16.clr_err = 1'b1;
        tick();
        b16.clr_err = 1'b0;
        check("clr_again_unf", 32'(b16.underflow), 0);

        // steady state at count 8 with simultaneous push/pop
        for (int i = 0; i < 8; i++) begin
            b16.wr_en = 1'b1;
            b16.din   = 8'(32'h20 + i);
            tick();
        end
        b16.wr_en = 1'b0;
        check("ss_count0", 32'(b16.count), 8);
        for (int k = 0; k < 20; k++) begin
            b16.wr_en = 1'b1;
            b16.rd_en = 1'b1;
            b16.din   = 8'(32'h28 + k);
            tick();
            check("ss_dout",  32'(b16.dout), 32'h20 + k);
            check("ss_dv",    32'(b16.dout_valid), 1);
            check("ss_count", 32'(b16.count), 8);
            check("ss_flags", 32'({b16.full, b16.empty, b16.almost_full, b16.almost_empty}), 0);
        end
        b16.wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("ss_tail", 32'(b16.dout), 32'h34 + i);
        end
        b16.rd_en = 1'b0;
        tick();
        check("ss_empty", 32'(b16.empty), 1);

        // asynchronous reset in the middle of a burst
        b16.rd_en = 1'b1;
        tick();
        b16.rd_en = 1'b0;
        check("pre_rst_unf", 32'(b16.underflow), 1);
        for (int i = 0; i < 7; i++) begin
            b16.wr_en = 1'b1;
            b16.din   = 8'(32'h40 + i);
            tick();
        end
        check("pre_rst_count", 32'(b16.count), 7);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(b16.count), 0);
        check("mid_rst_empty", 32'(b16.empty), 1);
        check("mid_rst_ae",    32'(b16.almost_empty), 1);
        check("mid_rst_unf",   32'(b16.underflow), 0);
        check("mid_rst_ovf",   32'(b16.overflow), 0);
        check("mid_rst_dout",  32'(b16.dout), 0);
        b16.wr_en = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        b16.wr_en = 1'b1;
        b16.din   = 8'h55;
        tick();
        b16.din   = 8'h66;
        tick();
        b16.wr_en = 1'b0;
        check("post_rst_count", 32'(b16.count), 2);
        b16.rd_en = 1'b1;
        tick();
        check("post_rst_d0", 32'(b16.dout), 32'h55);
        tick();
        check("post_rst_d1", 32'(b16.dout), 32'h66);
        b16.rd_en = 1'b0;
        tick();

        // DEPTH=5: pointers wrap explicitly
        for (int i = 0; i < 5; i++) begin
            b5.wr_en = 1'b1;
            b5.din   = 8'(32'hA0 + i);
            tick();
            check("d5_count", 32'(b5.count), i + 1);
            check("d5_af",    32'(b5.almost_full), 32'(i + 1 >= 3));
        end
        b5.wr_en = 1'b0;
        check("d5_full", 32'(b5.full), 1);
        b5.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("d5_rd", 32'(b5.dout), 32'hA0 + i);
        end
        b5.rd_en = 1'b0;
        check("d5_mid_count", 32'(b5.count), 2);
        b5.wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b5.din = 8'(32'hA5 + i);
            tick();
        end
        b5.wr_en = 1'b0;
        check("d5_wrap_full",  32'(b5.full), 1);
        check("d5_wrap_count", 32'(b5.count), 5);
        check("d5_no_ovf",     32'(b5.overflow), 0);
        b5.rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("d5_drain", 32'(b5.dout), 32'hA3 + i);
        end
        b5.rd_en = 1'b0;
        check("d5_empty", 32'(b5.empty), 1);
        check("d5_no_unf", 32'(b5.underflow), 0);

        // FWFT
        check("fw_idle_dv",   32'(bfw.dout_valid), 0);
        check("fw_idle_dout", 32'(bfw.dout), 0);
        bfw.wr_en = 1'b1;
        bfw.din   = 8'hAA;
        tick();
        bfw.wr_en = 1'b0;
        check("fw_dout",  32'(bfw.dout), 32'hAA);
        check("fw_dv",    32'(bfw.dout_valid), 1);
        check("fw_empty", 32'(bfw.empty), 0);
        check("fw_count", 32'(bfw.count), 1);
        bfw.rd_en = 1'b1;
        tick();
        bfw.rd_en = 1'b0;
        check("fw_pop_empty", 32'(bfw.empty), 1);
        check("fw_pop_dv",    32'(bfw.dout_valid), 0);
        check("fw_pop_count", 32'(bfw.count), 0);
        bfw.wr_en = 1'b1;
        bfw.din   = 8'hBB;
        tick();
        check("fw_head0", 32'(bfw.dout), 32'hBB);
        bfw.din   = 8'hCC;
        tick();
        bfw.wr_en = 1'b0;
        check("fw_head_hold", 32'(bfw.dout), 32'hBB);
        bfw.rd_en = 1'b1;
        tick();
        check("fw_head1", 32'(bfw.dout), 32'hCC);
        tick();
        bfw.rd_en = 1'b0;
        check("fw_final_empty", 32'(bfw.empty), 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
